// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// ---------------------
// Control unit for a multi-cycle RISC-V core built around one shared ALU.
// It decodes the latched instruction fields and steps a one-state-per-cycle
// FSM that drives the datapath multiplexers, enables and ALU function.
//
// Parameters
//   MEM_HANDSHAKE  0: memory completes in one cycle (memReady ignored)
//                  1: FETCH / MEMREAD / MEMWRITE wait for memReady
//   ILLEGAL_TRAP   1: unsupported encoding parks in HALT until rst
//                  0: unsupported encoding retires as a NOP
//   CNT_W          width of retiredCount
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op, func3, func7    instruction[6:0], [14:12], [30]
//   zero, neg           ALU result flags (branch resolution)
//   memReady            memory access completes this cycle
//   PCWrite, IRWrite, regWrite, memWrite, memRead, adrSrc   enables/selects
//   resultSrc           00 ALUOut, 01 MemData, 10 ALU result
//   ALUSrcA             00 PC, 01 OldPC, 10 A reg
//   ALUSrcB             00 B reg, 01 imm, 10 const 4
//   ALUControl          000 add 001 sub 010 and 011 or 100 slt 101 xor
//                       110 sltu 111 pass B
//   immSrc              000 I, 001 S, 010 B, 011 J, 100 U
//   retired             pulse on the last cycle of a completed instruction
//   retiredCount        completed-instruction count, wraps
//   halted              high while parked in HALT
module riscv_multicycle_ctrl #(
    parameter int MEM_HANDSHAKE = 0,
    parameter int ILLEGAL_TRAP  = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    input  logic             neg,
    input  logic             memReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             regWrite,
    output logic             memWrite,
    output logic             memRead,
    output logic             adrSrc,
    output logic [1:0]       resultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       immSrc,
    output logic             retired,
    output logic [CNT_W-1:0] retiredCount,
    output logic             halted
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JLINK,
        S_LUI,
        S_ILLEGAL,
        S_HALT
    } state_t;

    // Where an unsupported encoding ends up after its one dead cycle.
    localparam state_t ILLEGAL_EXIT = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;

    state_t           state;
    state_t           next_state;
    logic             mem_done;
    logic             alu_ok;
    logic [2:0]       alu_fn;
    logic             br_ok;
    logic             br_take;
    logic [CNT_W-1:0] count;

    // Without the handshake every memory access completes in its first cycle.
    assign mem_done = (MEM_HANDSHAKE != 0) ? memReady : 1'b1;

    // func3 -> ALU function, shared by EXECR and EXECI; func7 only picks
    // sub for register-register operations.
    always_comb begin
        alu_ok = 1'b1;
        alu_fn = ALU_ADD;
        case (func3)
            3'b000:  alu_fn = (state == S_EXECR && func7) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_fn = ALU_AND;
            3'b110:  alu_fn = ALU_OR;
            3'b100:  alu_fn = ALU_XOR;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_ok   = 1'b1;
        br_take = 1'b0;
        case (func3)
            3'b000:  br_take = zero;
            3'b001:  br_take = ~zero;
            3'b100:  br_take = neg;
            3'b101:  br_take = ~neg;
            default: br_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        memRead    = 1'b0;
        adrSrc     = 1'b0;
        resultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        immSrc     = IMM_I;

        case (state)
            S_FETCH: begin
                memRead   = 1'b1;
                ALUSrcB   = 2'b10;
                resultSrc = 2'b10;
                // IR and PC load only on the cycle the fetch completes.
                if (mem_done) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BR:        next_state = S_BRANCH;
                    OP_JAL:       next_state = S_JAL;
                    OP_JALR:      next_state = S_JALR;
                    OP_LUI:       next_state = S_LUI;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                immSrc     = (op == OP_SW) ? IMM_S : IMM_I;
                next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                memRead = 1'b1;
                if (mem_done) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultSrc  = 2'b01;
                regWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                if (mem_done) begin
                    next_state = S_FETCH;
                end
            end
            // An unsupported func3 turns this cycle into the dead cycle:
            // nothing is driven and the FSM leaves through ILLEGAL_EXIT.
            S_EXECR: begin
                if (alu_ok) begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b00;
                    ALUControl = alu_fn;
                    next_state = S_ALUWB;
                end else begin
                    next_state = ILLEGAL_EXIT;
                end
            end
            S_EXECI: begin
                if (alu_ok) begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    immSrc     = IMM_I;
                    ALUControl = alu_fn;
                    next_state = S_ALUWB;
                end else begin
                    next_state = ILLEGAL_EXIT;
                end
            end
            S_ALUWB: begin
                resultSrc  = 2'b00;
                regWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                if (br_ok) begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b00;
                    ALUControl = ALU_SUB;
                    resultSrc  = 2'b00;
                    PCWrite    = br_take;
                    next_state = S_FETCH;
                end else begin
                    next_state = ILLEGAL_EXIT;
                end
            end
            S_JAL: begin
                // Target was computed in DECODE and sits in ALUOut.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                resultSrc  = 2'b00;
                PCWrite    = 1'b1;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                immSrc     = IMM_I;
                resultSrc  = 2'b10;
                PCWrite    = 1'b1;
                next_state = S_JLINK;
            end
            S_JLINK: begin
                // Link value OldPC+4 is formed after the PC has moved.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB    = 2'b01;
                immSrc     = IMM_U;
                ALUControl = ALU_PASS;
                next_state = S_ALUWB;
            end
            S_ILLEGAL: begin
                next_state = ILLEGAL_EXIT;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Completion is a transition into FETCH from any other state; a reset
    // forcing FETCH is not a completion.
    assign retired = (next_state == S_FETCH) && (state != S_FETCH) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (retired) begin
            count <= count + CNT_ONE;
        end
    end

    assign retiredCount = count;
    assign halted       = (state == S_HALT);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomised bench for riscv_multicycle_ctrl. Two instances share the
// instruction/flag/memReady inputs; one is exercised at a time while the
// other is held in reset. Instance a: handshake on, NOP policy, 4-bit count.
// Instance b: handshake off, trap policy, 32-bit count.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7, zero, neg, memReady;

    logic       PCWrite_a, IRWrite_a, regWrite_a, memWrite_a, memRead_a, adrSrc_a;
    logic [1:0] resultSrc_a, ALUSrcA_a, ALUSrcB_a;
    logic [2:0] ALUControl_a, immSrc_a;
    logic       retired_a, halted_a;
    logic [3:0] cnt_a;

    logic        PCWrite_b, IRWrite_b, regWrite_b, memWrite_b, memRead_b, adrSrc_b;
    logic [1:0]  resultSrc_b, ALUSrcA_b, ALUSrcB_b;
    logic [2:0]  ALUControl_b, immSrc_b;
    logic        retired_b, halted_b;
    logic [31:0] cnt_b;

    riscv_multicycle_ctrl #(.MEM_HANDSHAKE(1), .ILLEGAL_TRAP(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .neg(neg), .memReady(memReady),
        .PCWrite(PCWrite_a), .IRWrite(IRWrite_a), .regWrite(regWrite_a),
        .memWrite(memWrite_a), .memRead(memRead_a), .adrSrc(adrSrc_a),
        .resultSrc(resultSrc_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
        .ALUControl(ALUControl_a), .immSrc(immSrc_a), .retired(retired_a),
        .retiredCount(cnt_a), .halted(halted_a)
    );

    riscv_multicycle_ctrl #(.MEM_HANDSHAKE(0), .ILLEGAL_TRAP(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst_b), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .neg(neg), .memReady(memReady),
        .PCWrite(PCWrite_b), .IRWrite(IRWrite_b), .regWrite(regWrite_b),
        .memWrite(memWrite_b), .memRead(memRead_b), .adrSrc(adrSrc_b),
        .resultSrc(resultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
        .ALUControl(ALUControl_b), .immSrc(immSrc_b), .retired(retired_b),
        .retiredCount(cnt_b), .halted(halted_b)
    );

    // Output vector: {retired, halted, PCWrite, IRWrite, regWrite, memWrite,
    //                 memRead, adrSrc, resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc}
    bit          sel;
    logic [19:0] vec_a, vec_b, obs_vec;
    logic [31:0] obs_cnt;
    assign vec_a = {retired_a, halted_a, PCWrite_a, IRWrite_a, regWrite_a, memWrite_a,
                    memRead_a, adrSrc_a, resultSrc_a, ALUSrcA_a, ALUSrcB_a,
                    ALUControl_a, immSrc_a};
    assign vec_b = {retired_b, halted_b, PCWrite_b, IRWrite_b, regWrite_b, memWrite_b,
                    memRead_b, adrSrc_b, resultSrc_b, ALUSrcA_b, ALUSrcB_b,
                    ALUControl_b, immSrc_b};
    assign obs_vec = sel ? vec_b : vec_a;
    assign obs_cnt = sel ? cnt_b : {28'b0, cnt_a};

    int total = 0;
    int bad   = 0;
    int unsigned exp_count;

    typedef struct packed {
        logic        mem;
        logic [19:0] v;
    } step_t;

    step_t plan[$];
    bit    plan_halts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [19:0] mk(input logic pcw, input logic irw, input logic rw,
                                        input logic mw, input logic mr, input logic as,
                                        input logic [1:0] rs, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [2:0] alu,
                                        input logic [2:0] imm);
        return {1'b0, 1'b0, pcw, irw, rw, mw, mr, as, rs, sa, sb, alu, imm};
    endfunction

    // {valid, ALU code} for a func3, with the sub selection only for R-type.
    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic use_sub);
        case (f3)
            3'd0:    return use_sub ? 4'b1001 : 4'b1000;
            3'd7:    return 4'b1010;
            3'd6:    return 4'b1011;
            3'd4:    return 4'b1101;
            3'd2:    return 4'b1100;
            3'd3:    return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == OP_R || o == OP_I || o == OP_LW || o == OP_SW || o == OP_BR ||
               o == OP_JAL || o == OP_JALR || o == OP_LUI;
    endfunction

    function automatic logic [31:0] exp_cnt();
        return sel ? exp_count : (exp_count % 16);
    endfunction

    task automatic push(input logic m, input logic [19:0] v);
        step_t s;
        s.mem = m;
        s.v   = v;
        plan.push_back(s);
    endtask

    task automatic push_illegal();
        push(1'b0, 20'h0);
        if (sel) plan_halts = 1'b1;
    endtask

    task automatic build_plan(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input logic n);
        logic [3:0] am;
        logic       take;
        bit         bok;
        plan.delete();
        plan_halts = 1'b0;
        push(1'b1, mk(1, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000));
        push(1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000,
                      (o == OP_JAL) ? 3'b011 : 3'b010));
        if (o == OP_LW) begin
            push(1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
            push(1'b1, mk(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
            push(1'b0, mk(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));
        end else if (o == OP_SW) begin
            push(1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001));
            push(1'b1, mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        end else if (o == OP_R || o == OP_I) begin
            am = alu_map(f3, (o == OP_R) && f7);
            if (am[3]) begin
                push(1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_R) ? 2'b00 : 2'b01,
                              am[2:0], 3'b000));
                push(1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
            end else begin
                push_illegal();
            end
        end else if (o == OP_BR) begin
            bok  = 1'b1;
            take = 1'b0;
            case (f3)
                3'd0:    take = z;
                3'd1:    take = !z;
                3'd4:    take = n;
                3'd5:    take = !n;
                default: bok = 1'b0;
            endcase
            if (bok) push(1'b0, mk(take, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000));
            else     push_illegal();
        end else if (o == OP_JAL) begin
            push(1'b0, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000));
            push(1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        end else if (o == OP_JALR) begin
            push(1'b0, mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000));
            push(1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000));
            push(1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        end else if (o == OP_LUI) begin
            push(1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b111, 3'b100));
            push(1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        end else begin
            push_illegal();
        end
        if (!plan_halts) plan[plan.size() - 1].v[19] = 1'b1;
    endtask

    task automatic halt_watch();
        for (int i = 0; i < 20; i++) begin
            op       = 7'($urandom);
            func3    = 3'($urandom);
            func7    = 1'($urandom);
            zero     = 1'($urandom);
            neg      = 1'($urandom);
            memReady = 1'($urandom);
            @(negedge clk);
            check("halt_out", {12'b0, obs_vec}, 32'h0004_0000);
            check("halt_count", obs_cnt, exp_cnt());
            @(posedge clk);
            #1;
        end
    endtask

    // fw/mw: wait cycles before memReady in FETCH / data access, -1 random.
    // abort: hold the data access stalled for two cycles and return mid-instruction.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic n, input int fw, input int mw,
                             input bit abort, output int cycles);
        step_t       st;
        int          stalls;
        int          target;
        bit          done;
        logic [19:0] ev;
        build_plan(o, f3, f7, z, n);
        op    = o;
        func3 = f3;
        func7 = f7;
        zero  = z;
        neg   = n;
        cycles = 0;
        for (int idx = 0; idx < plan.size(); idx++) begin
            st     = plan[idx];
            stalls = 0;
            target = (idx == 0) ? fw : mw;
            done   = 1'b0;
            while (!done) begin
                if (!sel && st.mem) begin
                    if (abort && idx > 0)  memReady = 1'b0;
                    else if (target >= 0)  memReady = (stalls >= target);
                    else                   memReady = (stalls >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    done = memReady;
                end else begin
                    memReady = (sel && target >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
                    done = 1'b1;
                end
                ev = st.v;
                if (!done) begin
                    ev[19] = 1'b0;
                    ev[17] = 1'b0;
                    ev[16] = 1'b0;
                end
                @(negedge clk);
                check($sformatf("out op=%b f3=%b f7=%b step=%0d stall=%0d", o, f3, f7, idx, stalls),
                      {12'b0, obs_vec}, {12'b0, ev});
                check("count", obs_cnt, exp_cnt());
                @(posedge clk);
                #1;
                cycles++;
                stalls++;
                if (abort && st.mem && idx > 0 && stalls == 2) return;
            end
        end
        if (plan_halts) halt_watch();
        else            exp_count++;
    endtask

    task automatic do_reset();
        if (sel) rst_b = 1'b1;
        else     rst_a = 1'b1;
        memReady = 1'b1;
        @(negedge clk);
        check("rst_retired", {31'b0, sel ? retired_b : retired_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_a = sel ? 1'b1 : 1'b0;
        rst_b = sel ? 1'b0 : 1'b1;
        exp_count = 0;
    endtask

    task automatic rand_instr(output logic [6:0] o, output logic [2:0] f3, output logic f7,
                              output logic z, output logic n);
        logic [6:0] ops [8];
        int k;
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI};
        k   = $urandom_range(0, 9);
        if (k < 8) begin
            o = ops[k];
        end else begin
            o = OP_FENCE;
            for (int t = 0; t < 16; t++) begin
                o = 7'($urandom);
                if (!is_legal(o)) break;
            end
            if (is_legal(o)) o = OP_FENCE;
        end
        f3 = 3'($urandom);
        f7 = 1'($urandom);
        z  = 1'($urandom);
        n  = 1'($urandom);
    endtask

    initial begin
        int cyc;
        logic [6:0] o;
        logic [2:0] f3;
        logic f7, z, n;
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        op = '0; func3 = '0; func7 = 1'b0; zero = 1'b0; neg = 1'b0; memReady = 1'b0;
        exp_count = 0;
        repeat (2) @(posedge clk);
        #1;

        // Instance a: handshake, NOP policy, 4-bit count
        do_reset();
        run_instr(OP_R, 3'd0, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_add", cyc, 4);
        run_instr(OP_LW, 3'd2, 1'b0, 0, 0, 2, 3, 0, cyc);
        check("lat_lw_waits", cyc, 10);
        run_instr(OP_BR, 3'd1, 1'b0, 1, 0, 0, 0, 0, cyc);
        check("lat_bne_z1", cyc, 3);
        run_instr(OP_BR, 3'd1, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_bne_z0", cyc, 3);
        run_instr(OP_JALR, 3'd0, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_jalr", cyc, 5);
        run_instr(OP_SW, 3'd2, 1'b0, 0, 0, 0, 4, 0, cyc);
        check("lat_sw_waits", cyc, 8);
        run_instr(OP_FENCE, 3'd0, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_illegal_nop", cyc, 3);
        run_instr(OP_R, 3'd1, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_bad_f3_nop", cyc, 3);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_instr(OP_LUI, 3'($urandom), 1'b0, 0, 0, 0, 0, 0, cyc);
        end
        check("lat_lui", cyc, 4);
        check("count_wrap", {28'b0, cnt_a}, 32'd1);

        for (int i = 0; i < 150; i++) begin
            rand_instr(o, f3, f7, z, n);
            run_instr(o, f3, f7, z, n, -1, -1, 0, cyc);
        end

        run_instr(OP_LW, 3'd2, 1'b0, 0, 0, 0, 0, 1, cyc);
        do_reset();
        run_instr(OP_JAL, 3'd0, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_jal", cyc, 4);

        // Instance b: no handshake, trap policy, 32-bit count
        rst_a = 1'b1;
        sel   = 1'b1;
        do_reset();
        run_instr(OP_LW, 3'd2, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_lw_nohs", cyc, 5);
        run_instr(OP_SW, 3'd2, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_sw_nohs", cyc, 4);
        run_instr(OP_FENCE, 3'd0, 1'b0, 0, 0, 0, 0, 0, cyc);
        check("lat_trap", cyc, 3);
        do_reset();
        run_instr(OP_BR, 3'd3, 1'b0, 0, 0, 0, 0, 0, cyc);
        do_reset();
        for (int i = 0; i < 120; i++) begin
            rand_instr(o, f3, f7, z, n);
            run_instr(o, f3, f7, z, n, -1, -1, 0, cyc);
            if (plan_halts) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Parametrised multi-cycle RISC-V control unit that replaces the fixed controller inside the core top. It decodes the latched instruction and sequences a one-state-per-cycle FSM to drive the shared-ALU datapath. Over the existing controller it adds an optional memory ready handshake for wait-state memories, a selectable illegal-instruction policy, LUI/JALR support and a retired-instruction counter.

## Interface
- MEM_HANDSHAKE, 0: 0 = single-cycle memory, `memReady` ignored; 1 = FETCH/MEMREAD/MEMWRITE stall until `memReady`=1.
- ILLEGAL_TRAP, 1: 1 = unsupported encoding enters sticky HALT; 0 = treated as NOP, returns to FETCH.
- CNT_W, 32: width of `retiredCount`.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instruction[6:0]; func3 in 3; func7 in 1 (instruction[30]).
- zero, neg  in  1  ALU flags of the current ALU result.
- memReady  in  1  memory access completes this cycle.
- PCWrite, IRWrite, regWrite, memWrite, memRead, adrSrc  out  1.
- resultSrc  out  2  00 ALUOut, 01 MemData reg, 10 ALU result.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A reg; ALUSrcB  out  2  00 B reg, 01 imm, 10 const 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sltu, 111 pass B.
- immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- retired  out  1  one-cycle pulse on last cycle of each completed instruction.
- retiredCount  out  CNT_W  retired instruction count, wraps modulo 2^CNT_W.
- halted  out  1  high in HALT.

## Operation
- Opcodes: 0110011 R, 0010011 I-ALU, 0000011 lw, 0100011 sw, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui; any other op is illegal.
- Unlisted outputs in any state: 0 / 000.
- FETCH: memRead=1, adrSrc=0, A=00, B=10, add, resultSrc=10; IRWrite=PCWrite=1 only in the completing cycle (every cycle if MEM_HANDSHAKE=0), then go to DECODE.
- DECODE: A=01, B=01, add, immSrc=J if op=jal else B. Branches to MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, JALR, LUI or ILLEGAL.
- MEMADR: A=10, B=01, add, immSrc=I (lw) / S (sw). Goes to MEMREAD or MEMWRITE.
- MEMREAD: adrSrc=1, memRead=1; wait for completion, then MEMWB.
- MEMWB: resultSrc=01, regWrite=1.
- MEMWRITE: adrSrc=1, memWrite=1 held until completion.
- EXECR: A=10, B=00. func3 000 selects add (func7=0) or sub (func7=1); 111 and, 110 or, 100 xor, 010 slt, 011 sltu. Then ALUWB.
- EXECI: A=10, B=01, immSrc=I, same func3 map, func7 ignored (always add for 000).
- ALUWB: resultSrc=00, regWrite=1.
- BRANCH: A=10, B=00, sub, resultSrc=00. PCWrite = zero (beq 000), !zero (bne 001), neg (blt 100), !neg (bge 101).
- JAL: A=01, B=10, add, resultSrc=00, PCWrite=1 (target from DECODE), then ALUWB.
- JALR: A=10, B=01, immSrc=I, add, resultSrc=10, PCWrite=1, then JLINK.
- JLINK: A=01, B=10, add, then ALUWB.
- LUI: B=01, immSrc=U, pass B, then ALUWB.
- Illegal: any unsupported func3 in EXECR, EXECI or BRANCH, and any illegal op in DECODE. That cycle drives no enables. Goes to HALT (TRAP=1; halted=1, absorbing, only rst exits) or FETCH (TRAP=0, retired=1).
- retired=1 on every transition into FETCH except from reset; retiredCount increments the same edge.

## Timing
- Reset: state FETCH, retiredCount=0, halted=0. Outputs are Moore decodes of state (plus memReady/flags), so FETCH values appear the cycle after reset.
- rst mid-instruction or in a stall wins over everything: next cycle is FETCH with no enable having fired.
- Latency with no waits: branch 3 cycles; R/I/sw/jal/lui 4; lw/jalr 5.
- Each memory state adds one cycle per memReady=0 cycle. During a stall, outputs stay constant except IRWrite/PCWrite, which are 0.
- memReady=1 on the first cycle gives zero stall.
- memWrite during MEMWRITE stalls stays high continuously.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7 0), no waits -> FETCH,DECODE,EXECR(ALUControl=000),ALUWB(regWrite=1); retired at cycle 4; count=1.
- lw with MEM_HANDSHAKE=1, memReady low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; IRWrite pulses exactly once.
- bne with zero=1, then zero=0 -> PCWrite 0 then 1 in BRANCH; 3 cycles each.
- jalr -> JALR PCWrite=1 resultSrc=10, then JLINK, ALUWB regWrite=1; 5 cycles.
- op=0001111 with TRAP=1 -> halted=1 and stays high 20 cycles, no enables; with TRAP=0 -> back to FETCH, retired=1.
- CNT_W=4, 17 back-to-back lui -> retiredCount wraps to 1; rst in MEMREAD stall -> FETCH next cycle, count=0.
